// File: rtl/id_stage_pkg.sv
// Shared widths, bus layouts and decode constants for the ID stage and its neighbours.
// Latency: n/a (types and helpers only).
// Backpressure: n/a.
package id_stage_pkg;

  localparam int FS_TO_DS_BUS_WD = 64;
  localparam int DS_TO_ES_BUS_WD = 136;
  localparam int BR_BUS_WD       = 33;
  localparam int WS_TO_RF_BUS_WD = 38;
  localparam int ES_FWD_BUS_WD   = 39;
  localparam int MS_FWD_BUS_WD   = 38;

  // alu_op bit indices, shared with exe_stage
  localparam int ALU_OP_WD = 12;
  localparam int ALU_ADD  = 0;
  localparam int ALU_SUB  = 1;
  localparam int ALU_SLT  = 2;
  localparam int ALU_SLTU = 3;
  localparam int ALU_AND  = 4;
  localparam int ALU_NOR  = 5;
  localparam int ALU_OR   = 6;
  localparam int ALU_XOR  = 7;
  localparam int ALU_SLL  = 8;
  localparam int ALU_SRL  = 9;
  localparam int ALU_SRA  = 10;
  localparam int ALU_LUI  = 11;

  localparam logic [5:0] OP_SPECIAL = 6'h00;
  localparam logic [5:0] OP_J       = 6'h02;
  localparam logic [5:0] OP_JAL     = 6'h03;
  localparam logic [5:0] OP_BEQ     = 6'h04;
  localparam logic [5:0] OP_BNE     = 6'h05;
  localparam logic [5:0] OP_ADDIU   = 6'h09;
  localparam logic [5:0] OP_LUI     = 6'h0f;
  localparam logic [5:0] OP_LW      = 6'h23;
  localparam logic [5:0] OP_SW      = 6'h2b;

  localparam logic [5:0] FN_SLL  = 6'h00;
  localparam logic [5:0] FN_SRL  = 6'h02;
  localparam logic [5:0] FN_SRA  = 6'h03;
  localparam logic [5:0] FN_JR   = 6'h08;
  localparam logic [5:0] FN_ADDU = 6'h21;
  localparam logic [5:0] FN_SUBU = 6'h23;
  localparam logic [5:0] FN_AND  = 6'h24;
  localparam logic [5:0] FN_OR   = 6'h25;
  localparam logic [5:0] FN_XOR  = 6'h26;
  localparam logic [5:0] FN_NOR  = 6'h27;
  localparam logic [5:0] FN_SLT  = 6'h2a;
  localparam logic [5:0] FN_SLTU = 6'h2b;

  typedef struct packed {
    logic [ALU_OP_WD-1:0] alu_op;
    logic                 load_op;
    logic                 src1_is_sa;
    logic                 src1_is_pc;
    logic                 src2_is_imm;
    logic                 src2_is_8;
    logic                 gr_we;
    logic                 mem_we;
    logic [4:0]           dest;
    logic [15:0]          imm;
    logic [31:0]          rs_value;
    logic [31:0]          rt_value;
    logic [31:0]          pc;
  } ds_to_es_t;

  typedef struct packed {
    logic        we;
    logic        is_load;
    logic [4:0]  dest;
    logic [31:0] result;
  } es_fwd_t;

  typedef struct packed {
    logic        we;
    logic [4:0]  dest;
    logic [31:0] result;
  } ms_fwd_t;

  typedef struct packed {
    logic        we;
    logic [4:0]  waddr;
    logic [31:0] wdata;
  } ws_rf_t;

  // Youngest producer wins: EXE, then MEM, then the WB write in flight, then the array.
  function automatic logic [31:0] fwd_select(input logic [4:0]  src,
                                             input es_fwd_t     es,
                                             input ms_fwd_t     ms,
                                             input ws_rf_t      ws,
                                             input logic [31:0] rf_val);
    if (src == 5'd0)                    return 32'd0;
    if (es.we && (es.dest == src))      return es.result;
    if (ms.we && (ms.dest == src))      return ms.result;
    if (ws.we && (ws.waddr == src))     return ws.wdata;
    return rf_val;
  endfunction

endpackage

// File: rtl/id_stage_regfile.sv
// 32x32 register file: two asynchronous read ports, one synchronous write port.
// Latency: reads combinational, writes visible after the write edge.
// Backpressure: none; writes to $0 are dropped and $0 always reads zero.
// Ports: clk; raddr1/rdata1, raddr2/rdata2 read ports; we/waddr/wdata write port.
module regfile (
  input  logic        clk,
  input  logic [4:0]  raddr1,
  output logic [31:0] rdata1,
  input  logic [4:0]  raddr2,
  output logic [31:0] rdata2,
  input  logic        we,
  input  logic [4:0]  waddr,
  input  logic [31:0] wdata
);

  logic [31:0] rf [32];

  always_ff @(posedge clk) begin
    if (we && (waddr != 5'd0)) begin
      rf[waddr] <= wdata;
    end
  end

  assign rdata1 = (raddr1 == 5'd0) ? 32'd0 : rf[raddr1];
  assign rdata2 = (raddr2 == 5'd0) ? 32'd0 : rf[raddr2];

endmodule

// File: rtl/id_stage.sv
// MIPS decode stage: latches {inst,pc} from IF, reads/forwards operands, resolves branches, feeds EXE.
// Latency: one instruction register; decode, forwarding and branch resolution are combinational from it.
// Backpressure: holds while EXE refuses or while a load-use hazard is pending; ex_flush kills the held instruction.
// Ports: clk/reset; fs_to_ds_valid/bus and ds_allowin from IF; ds_to_es_valid/bus and es_allowin to EXE;
//        br_bus back to IF; ws_to_rf_bus regfile write; es_fwd_bus/ms_fwd_bus forwarding; ex_flush from WB.
module id_stage
  import id_stage_pkg::*;
(
  input  logic                       clk,
  input  logic                       reset,
  input  logic                       es_allowin,
  output logic                       ds_allowin,
  input  logic                       fs_to_ds_valid,
  input  logic [FS_TO_DS_BUS_WD-1:0] fs_to_ds_bus,
  output logic                       ds_to_es_valid,
  output logic [DS_TO_ES_BUS_WD-1:0] ds_to_es_bus,
  output logic [BR_BUS_WD-1:0]       br_bus,
  input  logic [WS_TO_RF_BUS_WD-1:0] ws_to_rf_bus,
  input  logic [ES_FWD_BUS_WD-1:0]   es_fwd_bus,
  input  logic [MS_FWD_BUS_WD-1:0]   ms_fwd_bus,
  input  logic                       ex_flush
);

  logic        ds_valid;
  logic [31:0] ds_inst;
  logic [31:0] ds_pc;
  logic        ds_ready_go;
  logic        load_use_stall;

  es_fwd_t   es_fwd;
  ms_fwd_t   ms_fwd;
  ws_rf_t    ws_rf;
  ds_to_es_t ds_out;

  assign es_fwd = es_fwd_bus;
  assign ms_fwd = ms_fwd_bus;
  assign ws_rf  = ws_to_rf_bus;

  // Handshake
  assign ds_ready_go    = !load_use_stall;
  assign ds_allowin     = !ds_valid || (ds_ready_go && es_allowin);
  assign ds_to_es_valid = ds_valid && ds_ready_go && !ex_flush;

  always_ff @(posedge clk) begin
    if (reset) begin
      ds_valid <= 1'b0;
    end else if (ex_flush) begin
      ds_valid <= 1'b0;
    end else if (ds_allowin) begin
      ds_valid <= fs_to_ds_valid;
    end

    if (reset) begin
      ds_inst <= 32'd0;
      ds_pc   <= 32'd0;
    end else if (fs_to_ds_valid && ds_allowin) begin
      {ds_inst, ds_pc} <= fs_to_ds_bus;
    end
  end

  // Field extraction
  logic [5:0]  op, func;
  logic [4:0]  rs, rt, rd;
  logic [15:0] imm;
  logic [25:0] jidx;

  assign op   = ds_inst[31:26];
  assign rs   = ds_inst[25:21];
  assign rt   = ds_inst[20:16];
  assign rd   = ds_inst[15:11];
  assign func = ds_inst[5:0];
  assign imm  = ds_inst[15:0];
  assign jidx = ds_inst[25:0];

  logic is_special;
  logic inst_addu, inst_subu, inst_slt, inst_sltu, inst_and, inst_or, inst_xor, inst_nor;
  logic inst_sll, inst_srl, inst_sra, inst_jr;
  logic inst_addiu, inst_lui, inst_lw, inst_sw, inst_beq, inst_bne, inst_j, inst_jal;
  logic is_r_alu, uses_rs, uses_rt;

  assign is_special = (op == OP_SPECIAL);
  assign inst_addu  = is_special && (func == FN_ADDU);
  assign inst_subu  = is_special && (func == FN_SUBU);
  assign inst_slt   = is_special && (func == FN_SLT);
  assign inst_sltu  = is_special && (func == FN_SLTU);
  assign inst_and   = is_special && (func == FN_AND);
  assign inst_or    = is_special && (func == FN_OR);
  assign inst_xor   = is_special && (func == FN_XOR);
  assign inst_nor   = is_special && (func == FN_NOR);
  assign inst_sll   = is_special && (func == FN_SLL);
  assign inst_srl   = is_special && (func == FN_SRL);
  assign inst_sra   = is_special && (func == FN_SRA);
  assign inst_jr    = is_special && (func == FN_JR);
  assign inst_addiu = (op == OP_ADDIU);
  assign inst_lui   = (op == OP_LUI);
  assign inst_lw    = (op == OP_LW);
  assign inst_sw    = (op == OP_SW);
  assign inst_beq   = (op == OP_BEQ);
  assign inst_bne   = (op == OP_BNE);
  assign inst_j     = (op == OP_J);
  assign inst_jal   = (op == OP_JAL);

  assign is_r_alu = inst_addu | inst_subu | inst_slt | inst_sltu |
                    inst_and  | inst_or   | inst_xor | inst_nor;
  // Only sources an instruction really consumes may trigger a load-use stall.
  assign uses_rs  = is_r_alu | inst_addiu | inst_lw | inst_sw | inst_beq | inst_bne | inst_jr;
  assign uses_rt  = is_r_alu | inst_sll | inst_srl | inst_sra | inst_sw | inst_beq | inst_bne;

  // Operand read with forwarding
  logic [31:0] rf_rdata1, rf_rdata2, rs_value, rt_value;

  regfile u_regfile (
    .clk    (clk),
    .raddr1 (rs),
    .rdata1 (rf_rdata1),
    .raddr2 (rt),
    .rdata2 (rf_rdata2),
    .we     (ws_rf.we),
    .waddr  (ws_rf.waddr),
    .wdata  (ws_rf.wdata)
  );

  assign rs_value = fwd_select(rs, es_fwd, ms_fwd, ws_rf, rf_rdata1);
  assign rt_value = fwd_select(rt, es_fwd, ms_fwd, ws_rf, rf_rdata2);

  // A load in EXE has no data yet, so a consumer must wait one cycle for the MEM path.
  assign load_use_stall = ds_valid && es_fwd.we && es_fwd.is_load && (es_fwd.dest != 5'd0) &&
                          ((uses_rs && (es_fwd.dest == rs)) || (uses_rt && (es_fwd.dest == rt)));

  // Branch resolution
  logic [31:0] pc_plus4, br_offset, br_target;
  logic        br_cond, br_taken;

  assign pc_plus4  = ds_pc + 32'd4;
  assign br_offset = {{14{imm[15]}}, imm, 2'b00};
  assign br_cond   = (inst_beq && (rs_value == rt_value)) || (inst_bne && (rs_value != rt_value)) ||
                     inst_j || inst_jal || inst_jr;
  assign br_taken  = ds_valid && ds_ready_go && !ex_flush && br_cond;
  assign br_target = (inst_beq || inst_bne) ? (pc_plus4 + br_offset) :
                     inst_jr                ? rs_value :
                                              {pc_plus4[31:28], jidx, 2'b00};
  assign br_bus    = {br_taken, br_target};

  // Control bundle to EXE
  always_comb begin
    ds_out                   = '0;
    ds_out.alu_op[ALU_ADD]   = inst_addu | inst_addiu | inst_lw | inst_sw | inst_jal;
    ds_out.alu_op[ALU_SUB]   = inst_subu;
    ds_out.alu_op[ALU_SLT]   = inst_slt;
    ds_out.alu_op[ALU_SLTU]  = inst_sltu;
    ds_out.alu_op[ALU_AND]   = inst_and;
    ds_out.alu_op[ALU_NOR]   = inst_nor;
    ds_out.alu_op[ALU_OR]    = inst_or;
    ds_out.alu_op[ALU_XOR]   = inst_xor;
    ds_out.alu_op[ALU_SLL]   = inst_sll;
    ds_out.alu_op[ALU_SRL]   = inst_srl;
    ds_out.alu_op[ALU_SRA]   = inst_sra;
    ds_out.alu_op[ALU_LUI]   = inst_lui;
    ds_out.load_op           = inst_lw;
    ds_out.src1_is_sa        = inst_sll | inst_srl | inst_sra;
    ds_out.src1_is_pc        = inst_jal;
    ds_out.src2_is_imm       = inst_addiu | inst_lui | inst_lw | inst_sw;
    ds_out.src2_is_8         = inst_jal;
    ds_out.gr_we             = is_r_alu | inst_sll | inst_srl | inst_sra |
                               inst_addiu | inst_lui | inst_lw | inst_jal;
    ds_out.mem_we            = inst_sw;
    ds_out.dest              = (inst_addiu | inst_lui | inst_lw) ? rt :
                               inst_jal                          ? 5'd31 : rd;
    ds_out.imm               = imm;
    ds_out.rs_value          = rs_value;
    ds_out.rt_value          = rt_value;
    ds_out.pc                = ds_pc;
  end

  assign ds_to_es_bus = ds_out;

endmodule

// File: tb/tb_id_stage.sv
module tb_id_stage;

  logic         clk;
  logic         reset;
  logic         es_allowin;
  logic         ds_allowin;
  logic         fs_to_ds_valid;
  logic [63:0]  fs_to_ds_bus;
  logic         ds_to_es_valid;
  logic [135:0] ds_to_es_bus;
  logic [32:0]  br_bus;
  logic [37:0]  ws_to_rf_bus;
  logic [38:0]  es_fwd_bus;
  logic [37:0]  ms_fwd_bus;
  logic         ex_flush;

  int tests_run = 0;
  int failed    = 0;

  logic [31:0] mrf [32];  // architectural register model

  id_stage dut (
    .clk            (clk),
    .reset          (reset),
    .es_allowin     (es_allowin),
    .ds_allowin     (ds_allowin),
    .fs_to_ds_valid (fs_to_ds_valid),
    .fs_to_ds_bus   (fs_to_ds_bus),
    .ds_to_es_valid (ds_to_es_valid),
    .ds_to_es_bus   (ds_to_es_bus),
    .br_bus         (br_bus),
    .ws_to_rf_bus   (ws_to_rf_bus),
    .es_fwd_bus     (es_fwd_bus),
    .ms_fwd_bus     (ms_fwd_bus),
    .ex_flush       (ex_flush)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Output bundle fields
  wire [31:0] o_rs    = ds_to_es_bus[95:64];
  wire [31:0] o_rt    = ds_to_es_bus[63:32];
  wire [31:0] o_pc    = ds_to_es_bus[31:0];
  wire [4:0]  o_dest  = ds_to_es_bus[116:112];
  wire        o_memwe = ds_to_es_bus[117];
  wire        o_grwe  = ds_to_es_bus[118];
  wire        o_src8  = ds_to_es_bus[119];
  wire        o_srcpc = ds_to_es_bus[121];
  wire        o_taken = br_bus[32];
  wire [31:0] o_tgt   = br_bus[31:0];

  // Instruction encoders
  function automatic logic [31:0] r_inst(input logic [5:0] fn, input logic [4:0] rs, rt, rd);
    return {6'h00, rs, rt, rd, 5'd0, fn};
  endfunction
  function automatic logic [31:0] i_inst(input logic [5:0] op, input logic [4:0] rs, rt, input logic [15:0] imm);
    return {op, rs, rt, imm};
  endfunction

  // Mnemonic table: 0 addu 1 subu 2 slt 3 sltu 4 and 5 or 6 xor 7 nor 8 sll 9 srl 10 sra
  // 11 addiu 12 lui 13 lw 14 sw 15 beq 16 bne 17 j 18 jal 19 jr 20 undefined opcode 21 undefined funct
  function automatic logic [31:0] build(input int k, input logic [4:0] rs, rt, rd, input logic [15:0] imm,
                                        input logic [25:0] idx);
    case (k)
      0:  return r_inst(6'h21, rs, rt, rd);
      1:  return r_inst(6'h23, rs, rt, rd);
      2:  return r_inst(6'h2a, rs, rt, rd);
      3:  return r_inst(6'h2b, rs, rt, rd);
      4:  return r_inst(6'h24, rs, rt, rd);
      5:  return r_inst(6'h25, rs, rt, rd);
      6:  return r_inst(6'h26, rs, rt, rd);
      7:  return r_inst(6'h27, rs, rt, rd);
      8:  return r_inst(6'h00, rs, rt, rd);
      9:  return r_inst(6'h02, rs, rt, rd);
      10: return r_inst(6'h03, rs, rt, rd);
      11: return i_inst(6'h09, rs, rt, imm);
      12: return i_inst(6'h0f, rs, rt, imm);
      13: return i_inst(6'h23, rs, rt, imm);
      14: return i_inst(6'h2b, rs, rt, imm);
      15: return i_inst(6'h04, rs, rt, imm);
      16: return i_inst(6'h05, rs, rt, imm);
      17: return {6'h02, idx};
      18: return {6'h03, idx};
      19: return r_inst(6'h08, rs, rt, rd);
      20: return i_inst(6'h3e, rs, rt, imm);
      default: return r_inst(6'h3f, rs, rt, rd);
    endcase
  endfunction

  // Stimulus helpers
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic idle_inputs();
    fs_to_ds_valid = 1'b0;
    fs_to_ds_bus   = '0;
    ws_to_rf_bus   = '0;
    es_fwd_bus     = '0;
    ms_fwd_bus     = '0;
    ex_flush       = 1'b0;
    es_allowin     = 1'b1;
  endtask

  task automatic load_inst(input logic [31:0] inst, input logic [31:0] pc);
    es_allowin     = 1'b1;
    fs_to_ds_valid = 1'b1;
    fs_to_ds_bus   = {inst, pc};
    tick();
    fs_to_ds_valid = 1'b0;
  endtask

  task automatic ws_write(input logic [4:0] a, input logic [31:0] d);
    ws_to_rf_bus = {1'b1, a, d};
    tick();
    if (a != 5'd0) mrf[a] = d;
    ws_to_rf_bus = '0;
  endtask

  task automatic test_reset();
    idle_inputs();
    reset = 1'b1;
    for (int c = 0; c < 6; c++) begin
      if (c == 3) reset = 1'b0;
      tick();
      #2;
      tests_run++;
      if (ds_to_es_valid !== 1'b0) begin failed++; $display("FAIL reset_valid cyc%0d got %b want 0", c, ds_to_es_valid); end
      tests_run++;
      if (o_taken !== 1'b0) begin failed++; $display("FAIL reset_br_taken cyc%0d got %b want 0", c, o_taken); end
      tests_run++;
      if (ds_allowin !== 1'b1) begin failed++; $display("FAIL reset_allowin cyc%0d got %b want 1", c, ds_allowin); end
    end
    mrf[0] = 32'd0;
    for (int r = 1; r < 32; r++) ws_write(5'(r), $urandom);
  endtask

  task automatic test_ws_bypass();
    load_inst(r_inst(6'h21, 5'd8, 5'd0, 5'd9), 32'hbfc0_0000);
    es_allowin   = 1'b0;
    ws_to_rf_bus = {1'b1, 5'd8, 32'h1234};
    #2;
    tests_run++;
    if (o_rs !== 32'h1234) begin failed++; $display("FAIL ws_same_cycle got %h want 00001234", o_rs); end
    tests_run++;
    if (o_rt !== 32'h0) begin failed++; $display("FAIL ws_rt_zero got %h want 0", o_rt); end
    tick();
    mrf[8] = 32'h1234;
    ws_to_rf_bus = '0;
    #2;
    tests_run++;
    if (o_rs !== 32'h1234) begin failed++; $display("FAIL ws_later_rf got %h want 00001234", o_rs); end
    tests_run++;
    if (ds_to_es_valid !== 1'b1 || ds_allowin !== 1'b0)
      begin failed++; $display("FAIL ws_hold got v=%b a=%b want v=1 a=0", ds_to_es_valid, ds_allowin); end
    es_allowin = 1'b1;
  endtask

  task automatic test_load_use();
    load_inst(r_inst(6'h21, 5'd4, 5'd4, 5'd5), 32'hbfc0_0040);
    es_fwd_bus = {1'b1, 1'b1, 5'd4, 32'hdead_beef};
    #2;
    tests_run++;
    if (ds_allowin !== 1'b0 || ds_to_es_valid !== 1'b0)
      begin failed++; $display("FAIL lu_stall got a=%b v=%b want a=0 v=0", ds_allowin, ds_to_es_valid); end
    tick();
    es_fwd_bus = '0;
    ms_fwd_bus = {1'b1, 5'd4, 32'hA5A5_A5A5};
    #2;
    tests_run++;
    if (o_rs !== 32'hA5A5_A5A5 || o_rt !== 32'hA5A5_A5A5)
      begin failed++; $display("FAIL lu_ms_fwd got rs=%h rt=%h want a5a5a5a5", o_rs, o_rt); end
    tests_run++;
    if (ds_to_es_valid !== 1'b1 || ds_allowin !== 1'b1 || o_pc !== 32'hbfc0_0040)
      begin failed++; $display("FAIL lu_issue got v=%b a=%b pc=%h want 1 1 bfc00040", ds_to_es_valid, ds_allowin, o_pc); end
    tick();
    ms_fwd_bus = '0;
  endtask

  task automatic test_branch();
    ws_write(5'd1, 32'h55);
    ws_write(5'd2, 32'h55);
    load_inst(i_inst(6'h04, 5'd1, 5'd2, 16'hffff), 32'hbfc0_0010);
    #2;
    tests_run++;
    if (br_bus !== {1'b1, 32'hbfc0_0010}) begin failed++; $display("FAIL beq_taken got %h want 1bfc00010", br_bus); end
    ws_write(5'd2, 32'h66);
    load_inst(i_inst(6'h04, 5'd1, 5'd2, 16'hffff), 32'hbfc0_0010);
    #2;
    tests_run++;
    if (o_taken !== 1'b0) begin failed++; $display("FAIL beq_not_taken got %b want 0", o_taken); end
    load_inst({6'h03, 26'h000_0100}, 32'hbfc0_0020);
    #2;
    tests_run++;
    if (br_bus !== {1'b1, 32'hb000_0400}) begin failed++; $display("FAIL jal_target got %h want 1b0000400", br_bus); end
    tests_run++;
    if (o_dest !== 5'd31 || o_grwe !== 1'b1 || o_srcpc !== 1'b1 || o_src8 !== 1'b1)
      begin failed++; $display("FAIL jal_ctrl got dest=%0d we=%b pc=%b s8=%b want 31 1 1 1", o_dest, o_grwe, o_srcpc, o_src8); end
  endtask

  task automatic test_fwd_priority();
    load_inst(r_inst(6'h21, 5'd3, 5'd0, 5'd10), 32'h100);
    es_allowin   = 1'b0;
    es_fwd_bus   = {1'b1, 1'b0, 5'd3, 32'h1};
    ms_fwd_bus   = {1'b1, 5'd3, 32'h2};
    ws_to_rf_bus = {1'b1, 5'd3, 32'h3};
    #2;
    tests_run++;
    if (o_rs !== 32'h1) begin failed++; $display("FAIL prio_es got %h want 1", o_rs); end
    es_fwd_bus[38] = 1'b0;
    #1;
    tests_run++;
    if (o_rs !== 32'h2) begin failed++; $display("FAIL prio_ms got %h want 2", o_rs); end
    ms_fwd_bus[37] = 1'b0;
    #1;
    tests_run++;
    if (o_rs !== 32'h3) begin failed++; $display("FAIL prio_ws got %h want 3", o_rs); end
    ws_to_rf_bus = '0;
    load_inst(r_inst(6'h21, 5'd0, 5'd0, 5'd10), 32'h104);
    es_fwd_bus   = {1'b1, 1'b1, 5'd0, 32'hff};
    ms_fwd_bus   = {1'b1, 5'd0, 32'hee};
    ws_to_rf_bus = {1'b1, 5'd0, 32'hdd};
    #2;
    tests_run++;
    if (o_rs !== 32'h0 || o_rt !== 32'h0) begin failed++; $display("FAIL dest0 got rs=%h rt=%h want 0 0", o_rs, o_rt); end
    tests_run++;
    if (ds_to_es_valid !== 1'b1) begin failed++; $display("FAIL dest0_nostall got %b want 1", ds_to_es_valid); end
    tick();
    idle_inputs();
  endtask

  task automatic test_flush();
    load_inst(i_inst(6'h04, 5'd1, 5'd1, 16'h0004), 32'h200);
    #2;
    tests_run++;
    if (o_taken !== 1'b1) begin failed++; $display("FAIL flush_pre got %b want 1", o_taken); end
    ex_flush       = 1'b1;
    fs_to_ds_valid = 1'b1;
    fs_to_ds_bus   = {r_inst(6'h21, 5'd1, 5'd2, 5'd3), 32'h204};
    #1;
    tests_run++;
    if (ds_to_es_valid !== 1'b0 || o_taken !== 1'b0)
      begin failed++; $display("FAIL flush_same got v=%b br=%b want 0 0", ds_to_es_valid, o_taken); end
    tick();
    ex_flush       = 1'b0;
    fs_to_ds_valid = 1'b0;
    #2;
    tests_run++;
    if (ds_to_es_valid !== 1'b0 || o_taken !== 1'b0 || ds_allowin !== 1'b1)
      begin failed++; $display("FAIL flush_next got v=%b br=%b a=%b want 0 0 1", ds_to_es_valid, o_taken, ds_allowin); end
  endtask

  // Producers indexed by age: 0=EXE, 1=MEM, 2=WB
  logic        p_we   [3];
  logic [4:0]  p_dest [3];
  logic [31:0] p_val  [3];

  function automatic logic [31:0] model_read(input logic [4:0] r);
    if (r == 5'd0) return 32'd0;
    for (int i = 0; i < 3; i++) if (p_we[i] && p_dest[i] == r) return p_val[i];
    return mrf[r];
  endfunction

  task automatic test_random();
    for (int it = 0; it < 300; it++) begin
      int          k;
      logic [31:0] inst, pc, rsv, rtv, sx, e_tgt;
      logic [4:0]  rs, rt, rd, e_dest;
      logic        es_ld, urs, urt, stall, taken, e_we, eal;
      k    = $urandom_range(0, 21);
      inst = build(k, 5'($urandom_range(0, 7)), 5'($urandom_range(0, 7)), 5'($urandom_range(0, 31)),
                   16'($urandom), 26'($urandom));
      pc   = $urandom & 32'hffff_fffc;
      rs = inst[25:21]; rt = inst[20:16]; rd = inst[15:11];
      load_inst(inst, pc);
      for (int i = 0; i < 3; i++) begin
        p_we[i]   = ($urandom_range(0, 1) == 1);
        p_dest[i] = 5'($urandom_range(0, 7));
        p_val[i]  = ($urandom_range(0, 3) == 0) ? model_read(rs) : $urandom;
      end
      es_ld = ($urandom_range(0, 2) == 0);
      eal   = ($urandom_range(0, 3) != 0);
      es_fwd_bus   = {p_we[0], es_ld, p_dest[0], p_val[0]};
      ms_fwd_bus   = {p_we[1], p_dest[1], p_val[1]};
      ws_to_rf_bus = {p_we[2], p_dest[2], p_val[2]};
      es_allowin   = eal;
      rsv   = model_read(rs);
      rtv   = model_read(rt);
      urs   = (k inside {[0:7], 11, 13, 14, 15, 16, 19});
      urt   = (k inside {[0:10], 14, 15, 16});
      stall = p_we[0] && es_ld && p_dest[0] != 5'd0 && ((urs && p_dest[0] == rs) || (urt && p_dest[0] == rt));
      taken = !stall && ((k == 15 && rsv == rtv) || (k == 16 && rsv != rtv) || k == 17 || k == 18 || k == 19);
      sx    = {{16{inst[15]}}, inst[15:0]};
      if (k == 15 || k == 16) e_tgt = pc + 32'd4 + sx * 4;
      else if (k == 19)       e_tgt = rsv;
      else                    e_tgt = ((pc + 32'd4) & 32'hf000_0000) | {4'h0, inst[25:0], 2'b00};
      e_dest = (k inside {11, 12, 13}) ? rt : (k == 18) ? 5'd31 : rd;
      e_we   = (k inside {[0:13], 18});
      #2;
      tests_run++;
      if (ds_to_es_valid !== !stall || ds_allowin !== (!stall && eal))
        begin failed++; $display("FAIL rnd_hs it%0d k%0d got v=%b a=%b want v=%b a=%b", it, k, ds_to_es_valid, ds_allowin, !stall, !stall && eal); end
      tests_run++;
      if (o_rs !== rsv || o_rt !== rtv)
        begin failed++; $display("FAIL rnd_opnd it%0d got rs=%h rt=%h want rs=%h rt=%h", it, o_rs, o_rt, rsv, rtv); end
      tests_run++;
      if (o_taken !== taken || (taken && o_tgt !== e_tgt))
        begin failed++; $display("FAIL rnd_br it%0d k%0d got %b/%h want %b/%h", it, k, o_taken, o_tgt, taken, e_tgt); end
      tests_run++;
      if (o_dest !== e_dest || o_grwe !== e_we || o_memwe !== (k == 14))
        begin failed++; $display("FAIL rnd_ctrl it%0d k%0d got d=%0d we=%b mw=%b want d=%0d we=%b mw=%b", it, k, o_dest, o_grwe, o_memwe, e_dest, e_we, k == 14); end
      tick();
      if (p_we[2] && p_dest[2] != 5'd0) mrf[p_dest[2]] = p_val[2];
      idle_inputs();
    end
  endtask

  initial begin
    reset = 1'b1;
    idle_inputs();
    test_reset();
    test_ws_bypass();
    test_load_use();
    test_branch();
    test_fwd_priority();
    test_flush();
    test_random();
    $display("[TB] %0d tests run, %0d failed", tests_run, failed);
    $finish;
  end

endmodule
